// File: rtl/uart_tx_word.sv
// uart_tx_word: 8N1 UART transmitter that queues 32-bit words and sends each as 4 bytes, LSB byte first.
module uart_tx_word #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4,
   parameter int CNT_W        = 3
) (
   input  logic             clk_sys,
   input  logic             rst,
   input  logic [31:0]      word_in,
   input  logic             word_valid,
   output logic             word_ready,
   output logic             tx,
   output logic             busy,
   output logic [CNT_W-1:0] fifo_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t state_q, state_d;
   logic [31:0] mem_q [FIFO_DEPTH];
   logic [31:0] mem_d [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0] bit_q, bit_d;
   logic [1:0] byte_q, byte_d;
   logic [31:0] shift_q, shift_d;
   logic tx_q, tx_d, busy_q, busy_d;
   logic push, pop, has_word, last_tick;

   assign word_ready = count_q < FULL;
   assign push       = word_valid && word_ready;
   assign has_word   = count_q != '0;
   assign last_tick  = baud_q == BAUD_LAST;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign fifo_count = count_q;

   always_comb begin
      state_d = state_q;
      baud_d  = last_tick ? '0 : baud_q + BW'(1);
      bit_d   = bit_q;
      byte_d  = byte_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            pop    = has_word;
         end
         START: if (last_tick) begin
            state_d = DATA;
            bit_d   = '0;
            tx_d    = shift_q[{byte_q, 3'd0}];
         end
         DATA: if (last_tick) begin
            bit_d   = bit_q + 3'd1;
            state_d = (bit_q == 3'd7) ? STOP : DATA;
            tx_d    = (bit_q == 3'd7) ? 1'b1 : shift_q[{byte_q, bit_d}];
         end
         STOP: if (last_tick) begin
            // Bytes of a word and consecutive words run back to back.
            if (byte_q != 2'd3) begin
               byte_d  = byte_q + 2'd1;
               tx_d    = 1'b0;
               state_d = START;
            end else if (has_word) begin
               pop = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (pop) begin
         shift_d = mem_q[rd_ptr_q];
         byte_d  = '0;
         bit_d   = '0;
         baud_d  = '0;
         tx_d    = 1'b0;
         state_d = START;
      end
   end

   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = word_in;
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      busy_d   = (state_d != IDLE) || (count_d != '0);
   end

   always_ff @(posedge clk_sys) mem_q <= mem_d;

   always_ff @(posedge clk_sys) begin
      if (!rst) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         baud_q   <= '0;
         bit_q    <= '0;
         byte_q   <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         byte_q   <= byte_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_word.sv
// tb_uart_tx_word: pushes words, decodes the tx line and compares bytes against a scoreboard queue.
module tb_uart_tx_word;
   localparam int CPB = 4;

   logic clk_sys = 1'b0;
   logic rst = 1'b0;
   logic [31:0] word_in = '0;
   logic word_valid = 1'b0;
   logic word_ready, tx, busy;
   logic [2:0] fifo_count;

   uart_tx_word #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .CNT_W(3)) dut (
      .clk_sys(clk_sys), .rst(rst), .word_in(word_in), .word_valid(word_valid),
      .word_ready(word_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
   );

   always #5 clk_sys = ~clk_sys;

   int n_cmp = 0, n_bad = 0, cyc = 0;
   logic rst_q;
   logic [7:0] sb [$];
   int starts [$];
   int runs [$];
   logic mon_act = 1'b0;
   int ph, glitch, low_run = 0;
   logic [9:0] fv;
   int e, e2, e3, ai, guard, mx;
   logic ok;
   int acc [6];
   logic [31:0] words [6] = '{32'h11111111, 32'h22222222, 32'h33333333,
                              32'h44444444, 32'h55555555, 32'h66666666};

   always @(posedge clk_sys) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Line decoder: each bit is sampled on all CPB negedges and must stay stable.
   initial forever begin
      @(negedge clk_sys);
      if (rst_q !== 1'b1) begin
         mon_act = 1'b0;
         low_run = 0;
      end else begin
         if (tx === 1'b0) low_run++;
         else if (low_run > 0) begin
            runs.push_back(low_run);
            low_run = 0;
         end
         if (!mon_act) begin
            if (tx === 1'b0) begin
               mon_act = 1'b1;
               ph = 0;
               fv = '0;
               glitch = 0;
               starts.push_back(cyc);
            end
         end else begin
            ph++;
            if (ph % CPB == 0) fv[ph / CPB] = tx;
            else if (tx !== fv[ph / CPB]) glitch++;
            if (ph == 10 * CPB - 1) begin
               mon_act = 1'b0;
               check("bit_width", glitch, 0);
               check("stop_bit", fv[9], 1'b1);
               if (sb.size() == 0) check("unexpected_byte", sb.size(), 1);
               else check("byte", fv[8:1], sb.pop_front());
            end
         end
      end
   end

   task automatic drive_word(input logic [31:0] w, output int edge_no);
      check("ready_before_push", word_ready, 1'b1);
      word_in = w;
      word_valid = 1'b1;
      @(posedge clk_sys);
      @(negedge clk_sys);
      edge_no = cyc;
      word_valid = 1'b0;
      word_in = ~w;
      for (int k = 0; k < 4; k++) sb.push_back(w[8*k +: 8]);
   endtask

   task automatic wait_cyc(input int n);
      int g = 0;
      while (cyc < n && g < 20000) begin
         @(negedge clk_sys);
         g++;
      end
      check("wait_cyc", cyc, n);
   endtask

   task automatic wait_idle();
      int g = 0;
      while ((busy !== 1'b0 || sb.size() != 0 || mon_act) && g < 5000) begin
         @(negedge clk_sys);
         g++;
      end
      check("idle_timeout", g < 5000, 1'b1);
   endtask

   initial begin
      repeat (3) begin
         @(negedge clk_sys);
         check("rst_tx", tx, 1'b1);
         check("rst_busy", busy, 1'b0);
         check("rst_count", fifo_count, 0);
         check("rst_ready", word_ready, 1'b1);
      end
      rst = 1'b1;
      repeat (4) begin
         @(negedge clk_sys);
         check("post_rst_tx", tx, 1'b1);
         check("post_rst_busy", busy, 1'b0);
      end
      check("post_rst_frames", starts.size(), 0);

      drive_word(32'h12345678, e);
      check("tx_high_after_push", tx, 1'b1);
      @(negedge clk_sys);
      check("tx_start_fall", tx, 1'b0);
      check("busy_running", busy, 1'b1);
      wait_cyc(e + 160);
      check("busy_before_fall", busy, 1'b1);
      @(negedge clk_sys);
      check("busy_fall", busy, 1'b0);
      check("first_start_cycle", starts.size() > 0 ? starts[0] : -1, e + 1);
      check("single_frames", starts.size(), 4);
      wait_idle();

      runs.delete();
      drive_word(32'hFF00A55A, e);
      wait_idle();
      mx = 0;
      foreach (runs[k]) if (runs[k] > mx) mx = runs[k];
      check("zero_byte_low_run", mx, 9 * CPB);
      check("ff_byte_low_run", runs.size() > 0 ? runs[runs.size() - 1] : -1, CPB);

      starts.delete();
      ai = 0;
      guard = 0;
      word_in = words[0];
      word_valid = 1'b1;
      while (ai < 6 && guard < 2000) begin
         ok = word_ready;
         @(posedge clk_sys);
         @(negedge clk_sys);
         if (ok) begin
            acc[ai] = cyc;
            for (int k = 0; k < 4; k++) sb.push_back(words[ai][8*k +: 8]);
            ai++;
            if (ai == 5) begin
               check("full_ready", word_ready, 1'b0);
               check("full_count", fifo_count, 4);
            end
         end
         word_in = words[ai < 6 ? ai : 5];
         guard++;
      end
      word_valid = 1'b0;
      check("full_accepted", ai, 6);
      check("burst_accept", acc[4] - acc[0], 4);
      check("w5_accept", acc[5] - acc[0], 162);
      wait_idle();
      check("gapless", starts.size() == 24 ? starts[23] - starts[0] : -1, 23 * 40 * CPB / 4);
      check("burst_first_start", starts.size() > 0 ? starts[0] : -1, acc[0] + 1);

      starts.delete();
      drive_word(32'hCAFEF00D, e);
      drive_word(32'h0BADBEEF, e2);
      check("pushpop_idle_count", fifo_count, 1);
      wait_cyc(e + 160);
      check("sim_pre_count", fifo_count, 1);
      check("sim_stop_high", tx, 1'b1);
      drive_word(32'h5EED1234, e3);
      check("sim_edge", e3, e + 161);
      check("sim_count", fifo_count, 1);
      check("sim_start_low", tx, 1'b0);
      @(negedge clk_sys);
      check("sim_start_cycle", starts.size() > 4 ? starts[4] : -1, e + 161);
      wait_idle();

      drive_word(32'hA1A2A3A4, e);
      drive_word(32'hB1B2B3B4, e2);
      drive_word(32'hC1C2C3C4, e3);
      wait_cyc(e + 58);
      check("pre_rst_count", fifo_count, 2);
      rst = 1'b0;
      @(negedge clk_sys);
      sb.delete();
      check("midrst_tx", tx, 1'b1);
      check("midrst_busy", busy, 1'b0);
      check("midrst_count", fifo_count, 0);
      check("midrst_ready", word_ready, 1'b1);
      rst = 1'b1;
      repeat (2) @(negedge clk_sys);
      starts.delete();
      drive_word(32'h000000AA, e);
      wait_idle();
      repeat (200) @(negedge clk_sys);
      check("post_rst_frames", starts.size(), 4);
      check("post_rst_busy_idle", busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_tx_word.md
Name: uart_tx_word

Overview:
- UART 8N1 transmitter for the CPU board. It is the outbound counterpart of the rx serial loader feeding instruction fetch.
- Accepts 32-bit words over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each word as 4 bytes, least-significant byte first, onto the tx pin.
- Used to dump register, ecall and memory values to the host at the same baud as the loader.

Parameters:
- CLKS_PER_BIT, 868, clk_sys cycles per UART bit (100 MHz / 115200); legal range is 2 or more.
- FIFO_DEPTH, 4, word FIFO entries; must be a power of 2, 2 or more.
- CNT_W, 3, width of fifo_count; equals log2(FIFO_DEPTH)+1.

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- word_in  in  32  word to transmit.
- word_valid  in  1  word_in is valid this cycle.
- word_ready  out  1  FIFO can accept; combinational, equals (fifo_count < FIFO_DEPTH).
- tx  out  1  serial line, registered; idles high.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  out  CNT_W  words currently buffered, excluding the word being sent.

Behaviour:
- Reset (rst=0 at a clock edge):
  - tx=1, busy=0, fifo_count=0, word_ready=1.
  - FSM goes to IDLE; bit counter, byte index and baud counter go to 0.
  - Reset has priority over every other event.
  - Reset mid-frame truncates the frame: tx=1 after the next edge, and all buffered words are discarded.
- Push: word_valid & word_ready at an edge writes word_in to the FIFO tail.
  - Values presented while word_ready=0 are ignored.
  - Full (fifo_count = FIFO_DEPTH): word_ready=0, even if a pop occurs in the same cycle. No bypass.
- Pop: occurs at an edge where the FSM is in IDLE and fifo_count > 0, or in STOP on the final cycle of byte 3 with fifo_count > 0.
  - The popped word goes into a 32-bit shift register; byte index = 0.
  - At that same edge: tx <= 0 (start bit) and the FSM enters START.
  - Simultaneous push and pop: fifo_count is unchanged, and both words are handled correctly.
- FSM states are IDLE, START, DATA, STOP:
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. Bit source is shift_reg[byte_idx*8 + bit_idx]. Then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On its last cycle:
    - byte_idx < 3: increment byte_idx, tx <= 0, go to START. There is no idle gap between bytes.
    - byte_idx = 3 and FIFO non-empty: pop and go to START. There is no gap between words.
    - byte_idx = 3 and FIFO empty: go to IDLE.
- Baud counter:
  - Counts 0 to CLKS_PER_BIT-1 and wraps at the bit boundary.
  - Reloads to 0 on every state entry.
  - Every bit is exactly CLKS_PER_BIT cycles wide.
- Timing:
  - Word accepted at edge E into an empty, idle block: tx falls after edge E+1.
  - One word occupies 40*CLKS_PER_BIT cycles on the line.
- busy:
  - Registered. It is 1 from the pop edge until the edge ending the last stop bit with an empty FIFO.
  - It is also 1 whenever fifo_count > 0.
  - It falls at the same edge at which the FSM enters IDLE.
- word_in is sampled only at the push edge. A later change on word_in does not affect queued data.

Test Plan:
- Reset check: hold rst=0 for 3 cycles, then release. Required: tx=1, busy=0, fifo_count=0, word_ready=1 throughout, with no tx glitch.
- Single word, CLKS_PER_BIT=4: push 0x12345678 at edge E.
  - tx falls after E+1.
  - Frames decode to bytes 0x78, 0x56, 0x34, 0x12, each with start=0 and stop=1, each bit 4 cycles wide.
  - busy falls exactly 160 cycles after E+1.
- Bit patterns: push 0xFF00A55A. Required: bytes 0x5A, 0xA5, 0x00, 0xFF.
  - The 0x00 byte gives tx low for 9 bit-times (start plus 8 data).
  - The 0xFF byte gives tx low for only its start bit.
- Full FIFO, CLKS_PER_BIT=4, FIFO_DEPTH=4: drive word_valid continuously with 6 distinct words.
  - Words 0-4 are accepted in 5 consecutive cycles (w0 is popped during them).
  - word_ready then goes 0 with fifo_count=4.
  - Word 5 is accepted the cycle after the pop of w1.
  - All 6 words appear in order with zero idle cycles between frames.
- Simultaneous push/pop: push a new word exactly at the edge where byte 3 of the current word ends, with the FIFO holding 1 word. Required: fifo_count stays 1, and the next start bit immediately follows the stop bit.
- Reset mid-operation: assert rst=0 during bit 3 of byte 1 while fifo_count=2.
  - Required: tx=1, busy=0, fifo_count=0 after the next edge.
  - After release, a fresh push of 0x000000AA transmits only 0xAA, 0x00, 0x00, 0x00.
